rw_conflict_serializer: RTL and testbench



---
 rtl/rw_conflict_serializer_if.sv | 30 +++
 rtl/rw_conflict_serializer.sv | 138 +++++++++++++
 tb/tb_rw_conflict_serializer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rw_conflict_serializer_if.sv
// Enqueue/issue handshake bundle for rw_conflict_serializer.
// The serializer takes the slave view; the producer/consumer side takes master.
interface rw_conflict_serializer_if #(
    parameter int DATA_W   = 128,
    parameter int LOCALE_W = 32,
    parameter int TW       = 3
);
    logic                m_valid;
    logic                m_ready;
    logic [DATA_W-1:0]   m_data;
    logic [LOCALE_W-1:0] m_locale;
    logic                m_excl;

    logic                s_valid;
    logic                s_ready;
    logic [DATA_W-1:0]   s_data;
    logic [LOCALE_W-1:0] s_locale;
    logic                s_excl;
    logic [TW-1:0]       s_thread;

    modport slave (
        input  m_valid, m_data, m_locale, m_excl, s_ready,
        output m_ready, s_valid, s_data, s_locale, s_excl, s_thread
    );

    modport master (
        output m_valid, m_data, m_locale, m_excl, s_ready,
        input  m_ready, s_valid, s_data, s_locale, s_excl, s_thread
    );
endinterface

// File: rtl/rw_conflict_serializer.sv
// Age-ordered ready list issuing tasks to free threads when they conflict with
// no running task and no older queued task on the same locale (reader/writer rules).
module rw_conflict_serializer #(
    parameter int DATA_W    = 128,
    parameter int LOCALE_W  = 32,
    parameter int LOG_DEPTH = 4,
    parameter int N_THREADS = 8,
    parameter int AF_MARGIN = 4,
    localparam int TW       = $clog2(N_THREADS),
    localparam int DEPTH    = 2 ** LOG_DEPTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    rw_conflict_serializer_if.slave bus,
    input  logic                   unlock_valid,
    input  logic [TW-1:0]          unlock_thread,
    input  logic [TW:0]            active_threads,
    output logic [LOG_DEPTH:0]     count,
    output logic                   almost_full,
    output logic                   all_idle,
    output logic                   err_unlock
);
    localparam logic [LOG_DEPTH:0] DEPTH_C = (LOG_DEPTH+1)'(DEPTH);
    localparam logic [LOG_DEPTH:0] AF_C    = (LOG_DEPTH+1)'(DEPTH - AF_MARGIN);

    logic [DEPTH-1:0]     q_valid;
    logic [DEPTH-1:0]     q_excl;
    logic [LOCALE_W-1:0]  q_locale [DEPTH];
    logic [DATA_W-1:0]    q_data   [DEPTH];

    logic [N_THREADS-1:0] run;
    logic [N_THREADS-1:0] run_excl;
    logic [LOCALE_W-1:0]  run_locale [N_THREADS];

    logic [DEPTH-1:0]     blocked;
    logic [LOG_DEPTH-1:0] sel;
    logic                 sel_found;
    logic [TW-1:0]        thr;
    logic                 thr_found;
    logic                 issue;
    logic                 enq;
    logic                 unlock_ok;
    logic [LOG_DEPTH-1:0] wr_idx;

    // Blocking is rebuilt from registered state every cycle; nothing is cached.
    always_comb begin
        blocked = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            for (int unsigned t = 0; t < N_THREADS; t++)
                if (run[t] && run_locale[t] == q_locale[i] && (run_excl[t] || q_excl[i]))
                    blocked[i] = 1'b1;
            for (int unsigned j = 0; j < DEPTH; j++)
                if (j < i && q_valid[j] && q_locale[j] == q_locale[i] && (q_excl[j] || q_excl[i]))
                    blocked[i] = 1'b1;
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            if (!sel_found && q_valid[i] && !blocked[i]) begin
                sel_found = 1'b1;
                sel       = LOG_DEPTH'(i);
            end
        thr_found = 1'b0;
        thr       = '0;
        for (int unsigned t = 0; t < N_THREADS; t++)
            if (!thr_found && t < 32'(active_threads) && !run[t]) begin
                thr_found = 1'b1;
                thr       = TW'(t);
            end
    end

    assign bus.s_valid  = sel_found && thr_found;
    assign bus.s_data   = q_data[sel];
    assign bus.s_locale = q_locale[sel];
    assign bus.s_excl   = q_excl[sel];
    assign bus.s_thread = thr;
    assign bus.m_ready  = count < DEPTH_C;

    assign issue     = bus.s_valid && bus.s_ready;
    assign enq       = bus.m_valid && bus.m_ready;
    assign unlock_ok = (32'(unlock_thread) < N_THREADS) && run[unlock_thread];
    // The shift on issue frees slot count-1, so a concurrent enqueue lands there.
    assign wr_idx    = LOG_DEPTH'(issue ? count - 1'b1 : count);

    assign almost_full = count >= AF_C;
    assign all_idle    = (count == '0) && (run == '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q_valid    <= '0;
            q_excl     <= '0;
            run        <= '0;
            run_excl   <= '0;
            count      <= '0;
            err_unlock <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_locale[i] <= '0;
                q_data[i]   <= '0;
            end
            for (int unsigned t = 0; t < N_THREADS; t++)
                run_locale[t] <= '0;
        end else begin
            if (issue) begin
                for (int unsigned i = 0; i < DEPTH - 1; i++)
                    if (i >= 32'(sel)) begin
                        q_valid[i]  <= q_valid[i+1];
                        q_excl[i]   <= q_excl[i+1];
                        q_locale[i] <= q_locale[i+1];
                        q_data[i]   <= q_data[i+1];
                    end
                q_valid[DEPTH-1] <= 1'b0;
                run[thr]         <= 1'b1;
                run_locale[thr]  <= q_locale[sel];
                run_excl[thr]    <= q_excl[sel];
            end
            if (enq) begin
                q_valid[wr_idx]  <= 1'b1;
                q_excl[wr_idx]   <= bus.m_excl;
                q_locale[wr_idx] <= bus.m_locale;
                q_data[wr_idx]   <= bus.m_data;
            end
            if (unlock_valid) begin
                if (unlock_ok)
                    run[unlock_thread] <= 1'b0;
                else
                    err_unlock <= 1'b1;
            end
            case ({enq, issue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_rw_conflict_serializer.sv
// Directed bench for rw_conflict_serializer: exclusive chains, reader sharing,
// thread limits, full/simultaneous enqueue+issue, unlock errors and reset.
module tb_rw_conflict_serializer;
    logic        clk;
    logic        rstn;
    logic        unlock_valid;
    logic [2:0]  unlock_thread;
    logic [3:0]  active_threads;
    logic [4:0]  count;
    logic        almost_full;
    logic        all_idle;
    logic        err_unlock;

    int tests;
    int fails;

    rw_conflict_serializer_if #(.DATA_W(128), .LOCALE_W(32), .TW(3)) bus ();

    rw_conflict_serializer #(
        .DATA_W(128), .LOCALE_W(32), .LOG_DEPTH(4), .N_THREADS(8), .AF_MARGIN(4)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .unlock_valid(unlock_valid), .unlock_thread(unlock_thread),
        .active_threads(active_threads), .count(count),
        .almost_full(almost_full), .all_idle(all_idle), .err_unlock(err_unlock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic enq(input logic [31:0] loc, input logic x, input logic [127:0] d);
        bus.m_valid  = 1'b1;
        bus.m_locale = loc;
        bus.m_excl   = x;
        bus.m_data   = d;
        tick();
        bus.m_valid  = 1'b0;
    endtask

    task automatic unlock(input logic [2:0] t);
        unlock_valid  = 1'b1;
        unlock_thread = t;
        tick();
        unlock_valid  = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rstn = 1'b0;
        bus.m_valid = 1'b0; bus.m_data = '0; bus.m_locale = '0; bus.m_excl = 1'b0;
        bus.s_ready = 1'b0;
        unlock_valid = 1'b0; unlock_thread = '0; active_threads = 4'd8;
        tick(); tick();
        rstn = 1'b1;

        chk("rst_count", count, 0);
        chk("rst_m_ready", bus.m_ready, 1);
        chk("rst_s_valid", bus.s_valid, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_idle", all_idle, 1);
        chk("rst_err", err_unlock, 0);

        // Exclusive chain: A(5,X) B(5,X) C(7,X)
        enq(5, 1, 128'hA);
        chk("ex_latency_valid", bus.s_valid, 1);
        enq(5, 1, 128'hB);
        enq(7, 1, 128'hC);
        chk("ex_count3", count, 3);
        chk("ex_offer_a", bus.s_data, 128'hA);
        chk("ex_thr_a", bus.s_thread, 0);
        bus.s_ready = 1'b1;
        tick();
        chk("ex_offer_c", bus.s_data, 128'hC);
        chk("ex_thr_c", bus.s_thread, 1);
        tick();
        chk("ex_b_blocked", bus.s_valid, 0);
        chk("ex_count1", count, 1);
        unlock(0);
        chk("ex_b_valid", bus.s_valid, 1);
        chk("ex_offer_b", bus.s_data, 128'hB);
        chk("ex_thr_b", bus.s_thread, 0);
        tick();
        chk("ex_empty", bus.s_valid, 0);
        chk("ex_count0", count, 0);
        bus.s_ready = 1'b0;
        unlock(0);
        unlock(1);
        chk("ex_idle", all_idle, 1);

        // Readers: R1 R2 (9,S), W (9,X), R3 (9,S)
        enq(9, 0, 128'h11);
        enq(9, 0, 128'h12);
        enq(9, 1, 128'h13);
        enq(9, 0, 128'h14);
        chk("rd_offer_r1", bus.s_data, 128'h11);
        bus.s_ready = 1'b1;
        tick();
        chk("rd_offer_r2", bus.s_data, 128'h12);
        chk("rd_thr_r2", bus.s_thread, 1);
        tick();
        chk("rd_w_wait", bus.s_valid, 0);
        chk("rd_count2", count, 2);
        unlock(0);
        chk("rd_w_wait_one", bus.s_valid, 0);
        unlock(1);
        chk("rd_w_valid", bus.s_valid, 1);
        chk("rd_offer_w", bus.s_data, 128'h13);
        tick();
        chk("rd_r3_no_overtake", bus.s_valid, 0);
        unlock(0);
        chk("rd_offer_r3", bus.s_data, 128'h14);
        chk("rd_r3_valid", bus.s_valid, 1);
        tick();
        bus.s_ready = 1'b0;
        unlock(0);
        chk("rd_idle", all_idle, 1);

        // Threads: limited thread pool
        enq(21, 1, 128'h21);
        enq(22, 1, 128'h22);
        enq(23, 1, 128'h23);
        enq(24, 1, 128'h24);
        active_threads = 4'd0;
        #1;
        chk("th_zero_threads", bus.s_valid, 0);
        active_threads = 4'd2;
        #1;
        bus.s_ready = 1'b1;
        tick();
        chk("th_thr1", bus.s_thread, 1);
        tick();
        chk("th_no_thread", bus.s_valid, 0);
        chk("th_count2", count, 2);
        bus.s_ready = 1'b0;
        unlock(1);
        chk("th_reuse_valid", bus.s_valid, 1);
        chk("th_reuse_thr", bus.s_thread, 1);
        chk("th_reuse_data", bus.s_data, 128'h23);
        bus.s_ready = 1'b1;
        tick();
        chk("th_wait_again", bus.s_valid, 0);
        unlock(0);
        chk("th_thr0", bus.s_thread, 0);
        chk("th_data4", bus.s_data, 128'h24);
        tick();
        bus.s_ready = 1'b0;
        unlock(0);
        unlock(1);
        active_threads = 4'd8;
        chk("th_idle", all_idle, 1);

        // Errors: unlock of a non-running thread
        unlock(3);
        chk("err_set", err_unlock, 1);
        chk("err_count", count, 0);
        chk("err_idle", all_idle, 1);
        tick();
        chk("err_sticky", err_unlock, 1);

        // Full and simultaneous enqueue+issue
        for (int i = 0; i < 16; i++) begin
            enq(32'(100 + i), 0, 128'(256 + i));
            if (i == 10) chk("full_af_11", almost_full, 0);
            if (i == 11) chk("full_af_12", almost_full, 1);
        end
        chk("full_count16", count, 16);
        chk("full_m_ready", bus.m_ready, 0);
        bus.s_ready  = 1'b1;
        bus.m_valid  = 1'b1; bus.m_locale = 300; bus.m_excl = 1'b0; bus.m_data = 128'hDD;
        #1;
        chk("full_no_passthru", bus.m_ready, 0);
        tick();
        chk("full_count15", count, 15);
        bus.m_locale = 200; bus.m_data = 128'hEE;
        tick();
        bus.m_valid = 1'b0;
        bus.s_ready = 1'b0;
        chk("sim_count15", count, 15);
        chk("sim_slot14_data", dut.q_data[14], 128'hEE);
        chk("sim_slot14_valid", dut.q_valid[14], 1);

        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("rst2_count", count, 0);
        chk("rst2_err_clear", err_unlock, 0);
        chk("rst2_idle", all_idle, 1);

        // Reset mid-run: 6 queued, 3 running
        for (int i = 0; i < 9; i++) enq(32'(400 + i), 1, 128'(1024 + i));
        bus.s_ready = 1'b1;
        tick(); tick(); tick();
        bus.s_ready = 1'b0;
        chk("mid_count6", count, 6);
        chk("mid_busy", all_idle, 0);
        rstn = 1'b0;
        tick();
        chk("mid_rst_count", count, 0);
        chk("mid_rst_s_valid", bus.s_valid, 0);
        chk("mid_rst_idle", all_idle, 1);
        chk("mid_rst_m_ready", bus.m_ready, 1);
        rstn = 1'b1;
        enq(500, 1, 128'h55);
        chk("post_rst_valid", bus.s_valid, 1);
        chk("post_rst_thr", bus.s_thread, 0);
        chk("post_rst_data", bus.s_data, 128'h55);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
